// File: rtl/dna_reader.sv
// Serial reader for a device-DNA primitive: drives READ/SHIFT/CLK to it and
// captures DNA_BITS bits of DOUT, recirculating each sample back into DIN.
module dna_reader #(
    parameter int DNA_BITS    = 96,
    parameter int HALF_PERIOD = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    output logic                BUSY,
    output logic                VALID,
    output logic [DNA_BITS-1:0] DNA,
    output logic                DNA_CLK,
    output logic                DNA_READ,
    output logic                DNA_SHIFT,
    output logic                DNA_DIN,
    input  logic                DNA_DOUT
);

    localparam int BW = $clog2(DNA_BITS + 1);
    localparam logic [7:0]    HP_MAX   = 8'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DNA_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [7:0]          r_hp_cnt;
    logic [BW-1:0]       r_bit_cnt;
    logic [DNA_BITS-2:0] r_sr;
    logic [DNA_BITS-1:0] r_dna;
    logic                r_dna_clk, r_read, r_shift, r_din, r_valid;
    logic                w_start, w_wrap, w_fall, w_last;
    logic [DNA_BITS-1:0] w_sample;

    assign w_start  = START && (r_state != S_RUN);
    assign w_wrap   = (r_state == S_RUN) && (r_hp_cnt == HP_MAX);
    assign w_fall   = w_wrap && r_dna_clk;
    assign w_last   = w_fall && (r_bit_cnt == LAST_BIT);
    assign w_sample = {r_sr, DNA_DOUT};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (START) w_next = S_RUN;
            S_RUN:          if (w_last) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY = (r_state == S_RUN);
    end

    // READ/SHIFT only move on falling DNA_CLK toggles so they are stable at every rising edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hp_cnt  <= '0;
            r_bit_cnt <= '0;
            r_sr      <= '0;
            r_dna     <= '0;
            r_dna_clk <= 1'b0;
            r_read    <= 1'b0;
            r_shift   <= 1'b0;
            r_din     <= 1'b0;
            r_valid   <= 1'b0;
        end else if (w_start) begin
            r_read    <= 1'b1;
            r_shift   <= 1'b0;
            r_valid   <= 1'b0;
            r_bit_cnt <= '0;
            r_hp_cnt  <= '0;
            r_dna_clk <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (w_wrap) begin
                r_hp_cnt  <= '0;
                r_dna_clk <= ~r_dna_clk;
            end else begin
                r_hp_cnt <= r_hp_cnt + 8'd1;
            end
            if (w_fall) begin
                r_sr      <= w_sample[DNA_BITS-2:0];
                r_din     <= DNA_DOUT;
                r_bit_cnt <= r_bit_cnt + BW'(1);
                if (r_bit_cnt == '0) begin
                    r_read  <= 1'b0;
                    r_shift <= 1'b1;
                end
                if (w_last) begin
                    r_shift <= 1'b0;
                    r_dna   <= w_sample;
                    r_valid <= 1'b1;
                end
            end
        end else begin
            r_hp_cnt  <= '0;
            r_dna_clk <= 1'b0;
        end
    end

    assign VALID     = r_valid;
    assign DNA       = r_dna;
    assign DNA_CLK   = r_dna_clk;
    assign DNA_READ  = r_read;
    assign DNA_SHIFT = r_shift;
    assign DNA_DIN   = r_din;

endmodule

// File: tb/tb_dna_reader.sv
// Directed bench for dna_reader: two instances (HALF_PERIOD 1 and 3), each
// attached to a behavioural DNA primitive model updated on DNA_CLK rising edges.
module tb_dna_reader;

    typedef struct {
        int          u;
        logic [95:0] pat;
        int          lat;
    } vec_t;

    logic       CLK;
    logic [1:0] rst_n, start, busy, valid, dclk, rd, sh, din, dout;
    logic [95:0] dna [2];
    logic [95:0] mdl [2];
    logic [95:0] mpat [2];
    logic [95:0] last_dna [2];

    logic [1:0] pdclk, prd, psh, pvalid;
    int rises [2];
    int viol [2];
    int comps [2];

    int checks = 0;
    int errors = 0;

    localparam logic [95:0] P = 96'hA5A5_0123_4567_89AB_CDEF_FEDC;
    localparam logic [95:0] P2 = 96'h8000_0000_0000_0000_0000_0001;
    localparam logic [95:0] Q = 96'h3C3C_DEAD_BEEF_0F0F_1234_5678;

    dna_reader #(.DNA_BITS(96), .HALF_PERIOD(1)) u_dut0 (
        .CLK(CLK), .RST_N(rst_n[0]), .START(start[0]), .BUSY(busy[0]), .VALID(valid[0]),
        .DNA(dna[0]), .DNA_CLK(dclk[0]), .DNA_READ(rd[0]), .DNA_SHIFT(sh[0]),
        .DNA_DIN(din[0]), .DNA_DOUT(dout[0])
    );

    dna_reader #(.DNA_BITS(96), .HALF_PERIOD(3)) u_dut1 (
        .CLK(CLK), .RST_N(rst_n[1]), .START(start[1]), .BUSY(busy[1]), .VALID(valid[1]),
        .DNA(dna[1]), .DNA_CLK(dclk[1]), .DNA_READ(rd[1]), .DNA_SHIFT(sh[1]),
        .DNA_DIN(din[1]), .DNA_DOUT(dout[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign dout[0] = mdl[0][95];
    assign dout[1] = mdl[1][95];

    // Primitive model plus edge/protocol monitor, sampled mid-cycle.
    initial begin
        pdclk = '0; prd = '0; psh = '0; pvalid = '0;
        for (int u = 0; u < 2; u++) begin
            mdl[u] = '0; rises[u] = 0; viol[u] = 0; comps[u] = 0;
        end
    end

    always @(negedge CLK) begin
        for (int u = 0; u < 2; u++) begin
            if (!pdclk[u] && dclk[u]) begin
                rises[u]++;
                if (rd[u] !== prd[u] || sh[u] !== psh[u]) viol[u]++;
                if (rd[u])      mdl[u] = mpat[u];
                else if (sh[u]) mdl[u] = {mdl[u][94:0], din[u]};
            end
            if (!pvalid[u] && valid[u]) comps[u]++;
            pdclk[u]  = dclk[u];
            prd[u]    = rd[u];
            psh[u]    = sh[u];
            pvalid[u] = valid[u];
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_read(input int u, input logic [95:0] pat, input int lat,
                            input int ign1, input int ign2);
        int r0, c0, v0, cnt;
        logic [95:0] hold;
        hold = last_dna[u];
        mpat[u] = pat;
        r0 = rises[u]; c0 = comps[u]; v0 = viol[u];
        @(negedge CLK);
        start[u] = 1'b1;
        rst_n[u] = 1'b1;
        @(negedge CLK);
        start[u] = 1'b0;
        cnt = 0;
        chk("busy_after_start", 96'(busy[u]), 96'd1);
        chk("valid_drop_on_start", 96'(valid[u]), 96'd0);
        while (!valid[u] && cnt < lat + 50) begin
            @(negedge CLK);
            cnt++;
            start[u] = (cnt == ign1 || cnt == ign2);
            if (cnt == lat / 2) chk("dna_hold_mid_run", dna[u], hold);
        end
        start[u] = 1'b0;
        chk("valid_latency", 96'(cnt), 96'(lat));
        chk("dna_value", dna[u], pat);
        chk("busy_in_done", 96'(busy[u]), 96'd0);
        chk("dna_clk_rises", 96'(rises[u] - r0), 96'd96);
        chk("rd_sh_stable_at_rise", 96'(viol[u] - v0), 96'd0);
        repeat (4) @(negedge CLK);
        chk("one_completion", 96'(comps[u] - c0), 96'd1);
        chk("dna_clk_low_done", 96'(dclk[u]), 96'd0);
        last_dna[u] = pat;
    endtask

    vec_t vecs [5];

    initial begin
        int r0, c0, guard;
        vecs[0] = '{u: 0, pat: P,                                  lat: 192};
        vecs[1] = '{u: 1, pat: P2,                                 lat: 576};
        vecs[2] = '{u: 0, pat: 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, lat: 192};
        vecs[3] = '{u: 1, pat: 96'h0123_4567_89AB_CDEF_0F1E_2D3C, lat: 576};
        vecs[4] = '{u: 0, pat: 96'h0,                              lat: 192};

        rst_n = '0; start = '0;
        mpat[0] = '0; mpat[1] = '0; last_dna[0] = '0; last_dna[1] = '0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("reset_ctrl", 96'({busy[u], valid[u], dclk[u], rd[u], sh[u], din[u]}), 96'd0);
            chk("reset_dna", dna[u], 96'd0);
        end
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 5; i++)
            run_read(vecs[i].u, vecs[i].pat, vecs[i].lat, -1, -1);

        // Recirculation: DIN feeds samples back, leaving the model rotated by one.
        run_read(0, P, 192, -1, -1);
        chk("recirc_contents", mdl[0], {P[0], P[95:1]});
        run_read(0, P, 192, -1, -1);

        // START pulses mid-run must be ignored.
        run_read(0, P, 192, 10, 50);

        // Restart from DONE with a new pattern; DNA holds P until completion.
        run_read(0, Q, 192, -1, -1);
        run_read(0, P, 192, -1, -1);

        // Asynchronous reset at sample 40 aborts the run.
        mpat[0] = Q;
        r0 = rises[0];
        @(negedge CLK); start[0] = 1'b1;
        @(negedge CLK); start[0] = 1'b0;
        guard = 0;
        while (rises[0] - r0 < 40 && guard < 500) begin
            @(negedge CLK);
            guard++;
        end
        chk("reach_sample_40", 96'(rises[0] - r0 >= 40), 96'd1);
        #2 rst_n[0] = 1'b0;
        #1;
        chk("async_reset_ctrl", 96'({busy[0], valid[0], dclk[0], rd[0], sh[0], din[0]}), 96'd0);
        chk("async_reset_dna", dna[0], 96'd0);
        last_dna[0] = '0;
        @(negedge CLK); rst_n[0] = 1'b1;
        c0 = comps[0];
        repeat (300) @(negedge CLK);
        chk("no_resume_valid", 96'(comps[0] - c0), 96'd0);
        chk("no_resume_busy", 96'(busy[0]), 96'd0);
        rst_n[0] = 1'b0;
        run_read(0, P, 192, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dna_reader.md
DNA_READER -- requirements
Module: dna_reader

Interface
REQ-001 SHALL provide parameter DNA_BITS, default 96, meaning the number of DNA bits captured per read.
REQ-002 SHALL provide parameter HALF_PERIOD, default 2, meaning the number of CLK cycles per DNA_CLK half-period (legal range 1..255).
REQ-003 SHALL have port CLK, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port START, input, 1 bit: request a DNA read; sampled on the CLK edge.
REQ-006 SHALL have port BUSY, output, 1 bit: a read sequence is in progress.
REQ-007 SHALL have port VALID, output, 1 bit: DNA holds a complete capture.
REQ-008 SHALL have port DNA, output, DNA_BITS bits: captured value, first-sampled bit in the MSB.
REQ-009 SHALL have port DNA_CLK, output, 1 bit: registered clock driven to the DNA primitive.
REQ-010 SHALL have port DNA_READ, output, 1 bit: READ control driven to the primitive.
REQ-011 SHALL have port DNA_SHIFT, output, 1 bit: SHIFT control driven to the primitive.
REQ-012 SHALL have port DNA_DIN, output, 1 bit: serial data driven into the primitive.
REQ-013 SHALL have port DNA_DOUT, input, 1 bit: serial data returned from the primitive.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE; BUSY SHALL be 1 only in RUN.
REQ-015 SHALL accept START in IDLE or DONE and then, on the same edge: enter RUN, set DNA_READ=1, clear VALID, clear the bit counter, and start the half-period counter.
REQ-016 SHALL ignore START while in RUN.
REQ-017 SHALL, in RUN, count CLK cycles 0..HALF_PERIOD-1 and toggle DNA_CLK on each wrap of that count.
REQ-018 SHALL hold DNA_CLK at 0, with the half-period counter at 0, in IDLE and DONE.
REQ-019 SHALL, on each falling toggle of DNA_CLK, sample DNA_DOUT into an internal shift register {sr[DNA_BITS-2:0], DNA_DOUT} and increment the bit counter.
REQ-020 SHALL, on the first falling toggle, drive DNA_READ=0 and DNA_SHIFT=1.
REQ-021 SHALL change DNA_READ and DNA_SHIFT only on falling toggles, so that both are stable across every DNA_CLK rising edge.
REQ-022 SHALL, on the falling toggle that takes the DNA_BITS-th sample: drive DNA_SHIFT=0; load DNA with the completed shift register; set VALID=1; and enter DONE.
REQ-023 SHALL therefore produce exactly DNA_BITS DNA_CLK rising edges per sequence: one with READ=1, then DNA_BITS-1 with SHIFT=1.
REQ-024 SHALL drive DNA_DIN from a register holding the most recently sampled bit, so that the primitive contents recirculate.
REQ-025 SHALL assert VALID exactly DNA_BITS*2*HALF_PERIOD CLK cycles after the START-accepting edge (192*HALF_PERIOD cycles at the defaults).
REQ-026 SHALL keep DNA unchanged from one completion until the next completion, including through a restart; only VALID drops on restart.
REQ-027 SHALL use a bit counter wide enough for DNA_BITS with no wrap; sample DNA_BITS SHALL always terminate the sequence.

Reset
REQ-028 SHALL, on RST_N low, immediately force: state IDLE, BUSY=0, VALID=0, DNA=0, DNA_CLK=0, DNA_READ=0, DNA_SHIFT=0, DNA_DIN=0, and all counters to 0.
REQ-029 SHALL abort any sequence in progress on reset; it SHALL not resume afterwards, and a new START SHALL be required.
REQ-030 SHALL accept START on the first CLK edge after RST_N deasserts.

Verification
REQ-031 SHALL be verified with a bench DNA model that loads pattern P on READ with DOUT=P[95] and presents the next lower bit on each SHIFT. Scenario: P=96'hA5A5_0123_4567_89AB_CDEF_FEDC, HALF_PERIOD=1, single START -> DNA==P; VALID rises exactly 192 cycles after START; DNA_CLK shows 96 rising edges.
REQ-032 SHALL be verified with HALF_PERIOD=3 and P=96'h8000_0000_0000_0000_0000_0001 -> DNA==P at cycle 576; DNA_READ and DNA_SHIFT never toggle on a DNA_CLK rising edge.
REQ-033 SHALL be verified with START pulsed at cycles 10 and 50 of a run -> both pulses ignored; exactly one completion and 96 DNA_CLK rising edges.
REQ-034 SHALL be verified with RST_N pulsed low at sample 40 -> all outputs return to 0 asynchronously; no VALID follows; a later START yields DNA==P.
REQ-035 SHALL be verified with a restart from DONE using a new pattern Q -> VALID drops on the START edge; DNA holds P until completion, then DNA==Q.
REQ-036 SHALL be verified by a second read with no reload of the model -> the recirculated contents return DNA==P again.
